// File: rtl/enigma_pkg.sv
// Shared definitions for the Enigma final-RAM result reader: symbol/address
// widths, symbol code points and the reader FSM state type.
package enigma_pkg;

  localparam int SYMB_W = 6;
  localparam int ADDR_W = 4;

  localparam int SYMB_NONE = 0;
  localparam int SYMB_A    = 1;
  localparam int SYMB_Z    = 26;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    SEND,
    DONE
  } reader_state_t;

endpackage

// File: rtl/enigma_result_reader_if.sv
// Final-RAM read port plus valid/ready symbol stream between the result
// reader (master) and the RAM/sink side (slave).
interface enigma_result_reader_if;
    import enigma_pkg::*;

    logic              fr_rd_o;
    logic [ADDR_W-1:0] fr_addr_o;
    logic [SYMB_W-1:0] fr_data_i;
    logic [SYMB_W-1:0] out_symb_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic              out_last_o;
    logic              out_err_o;

    modport master (
        output fr_rd_o, fr_addr_o, out_symb_o, out_valid_o, out_last_o, out_err_o,
        input  fr_data_i, out_ready_i
    );

    modport slave (
        input  fr_rd_o, fr_addr_o, out_symb_o, out_valid_o, out_last_o, out_err_o,
        output fr_data_i, out_ready_i
    );

endinterface

// File: rtl/enigma_result_reader.sv
// Drains a run of encoded symbols from the final RAM and streams them out one
// at a time over valid/ready, flagging the last and out-of-range symbols.
module enigma_result_reader
    import enigma_pkg::*;
#(
    parameter int BASE_ADDR = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [ADDR_W-1:0]      symb_numb_i,
    output logic                   busy_o,
    output logic                   done_o,
    enigma_result_reader_if.master bus
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    reader_state_t     state_q;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] index_q;
    logic [ADDR_W-1:0] index_d;
    logic [ADDR_W-1:0] addr_q;
    logic [SYMB_W-1:0] symb_q;
    logic              rd_q;
    logic              valid_q;
    logic              last_q;
    logic              err_q;
    logic              busy_q;
    logic              done_q;
    logic              data_err;

    assign index_d  = index_q + ADDR_W'(1);
    assign data_err = (int'(bus.fr_data_i) == SYMB_NONE) || (int'(bus.fr_data_i) > SYMB_Z);

    // Every output is a register so the RAM strobe and stream are glitch-free.
    // NOTE: sequential state uses non-blocking (<=) so all registers update
    // together on the edge regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            count_q <= '0;
            index_q <= '0;
            addr_q  <= '0;
            symb_q  <= '0;
            rd_q    <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (symb_numb_i != '0) begin
                            count_q <= symb_numb_i;
                            index_q <= '0;
                            addr_q  <= BASE;
                            rd_q    <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= RD;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                RD: begin
                    rd_q    <= 1'b0;
                    state_q <= CAP;
                end
                CAP: begin
                    symb_q  <= bus.fr_data_i;
                    last_q  <= (index_q == count_q - ADDR_W'(1));
                    err_q   <= data_err;
                    valid_q <= 1'b1;
                    state_q <= SEND;
                end
                SEND: begin
                    // Symbol and flags hold until the sink takes them.
                    if (bus.out_ready_i) begin
                        valid_q <= 1'b0;
                        if (last_q) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            index_q <= index_d;
                            addr_q  <= BASE + index_d;
                            rd_q    <= 1'b1;
                            state_q <= RD;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign bus.fr_rd_o     = rd_q;
    assign bus.fr_addr_o   = addr_q;
    assign bus.out_symb_o  = symb_q;
    assign bus.out_valid_o = valid_q;
    assign bus.out_last_o  = last_q;
    assign bus.out_err_o   = err_q;

endmodule

// File: tb/tb_enigma_result_reader.sv
// Bench for enigma_result_reader: two instances (base 0 and base 12) behind
// synchronous RAM models, table-driven runs checked against a symbol-list model.
module tb_enigma_result_reader;
    import enigma_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] numb;
    logic              ready;
    int                sel;

    logic start0, start1, busy0, busy1, done0, done1;
    assign start0 = start && (sel == 0);
    assign start1 = start && (sel == 1);

    enigma_result_reader_if bus0 ();
    enigma_result_reader_if bus1 ();

    enigma_result_reader #(.BASE_ADDR(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start0), .symb_numb_i(numb),
        .busy_o(busy0), .done_o(done0), .bus(bus0.master)
    );
    enigma_result_reader #(.BASE_ADDR(12)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .symb_numb_i(numb),
        .busy_o(busy1), .done_o(done1), .bus(bus1.master)
    );

    logic [SYMB_W-1:0] ram0 [16];
    logic [SYMB_W-1:0] ram1 [16];

    always @(posedge clk) if (bus0.fr_rd_o) bus0.fr_data_i <= ram0[bus0.fr_addr_o];
    always @(posedge clk) if (bus1.fr_rd_o) bus1.fr_data_i <= ram1[bus1.fr_addr_o];
    assign bus0.out_ready_i = ready;
    assign bus1.out_ready_i = ready;

    logic              m_rd, m_valid, m_last, m_err, m_busy, m_done;
    logic [ADDR_W-1:0] m_addr;
    logic [SYMB_W-1:0] m_symb;
    assign m_rd    = (sel == 1) ? bus1.fr_rd_o     : bus0.fr_rd_o;
    assign m_addr  = (sel == 1) ? bus1.fr_addr_o   : bus0.fr_addr_o;
    assign m_valid = (sel == 1) ? bus1.out_valid_o : bus0.out_valid_o;
    assign m_symb  = (sel == 1) ? bus1.out_symb_o  : bus0.out_symb_o;
    assign m_last  = (sel == 1) ? bus1.out_last_o  : bus0.out_last_o;
    assign m_err   = (sel == 1) ? bus1.out_err_o   : bus0.out_err_o;
    assign m_busy  = (sel == 1) ? busy1 : busy0;
    assign m_done  = (sel == 1) ? done1 : done0;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ram_kind: 0 = ENIGMA word, 1 = wrap/invalid set, 2 = random contents
    typedef struct {
        string name;
        int    sel;
        int    n;            // -1 picks a random count 1..15
        int    ram_kind;
        int    stall_idx;    // symbol index held off by ready=0, -1 for none
        int    stall_len;
        bit    rnd_ready;
        int    restart_at;   // cycle for an ignored start pulse, -1 for none
        bit    start_in_done;
    } run_t;

    function automatic int ram_val(input int s, input int a);
        return (s == 1) ? int'(ram1[a]) : int'(ram0[a]);
    endfunction

    task automatic load_ram(input int kind);
        int enigma[6] = '{5, 14, 9, 7, 13, 1};
        for (int i = 0; i < 16; i++) begin
            ram0[i] = SYMB_W'(i + 30);
            ram1[i] = SYMB_W'(i + 30);
        end
        if (kind == 0) begin
            for (int i = 0; i < 6; i++) ram0[i] = SYMB_W'(enigma[i]);
        end else if (kind == 1) begin
            ram1[12] = 6'd3;  ram1[13] = 6'd4;  ram1[14] = 6'd5;
            ram1[15] = 6'd40; ram1[0]  = 6'd0;  ram1[1]  = 6'd26;
        end else begin
            for (int i = 0; i < 16; i++) begin
                ram0[i] = SYMB_W'($urandom_range(0, 40));
                ram1[i] = SYMB_W'($urandom_range(0, 40));
            end
        end
    endtask

    task automatic do_run(input run_t r);
        int n, base, first_v, done_cnt, done_c, last_acc, rd_stall, unstable, busy_bad, stall_ctr, prev_s;
        bit prev_v, prev_acc, finished, exp_busy;
        int addrs[$];
        int syms[$];
        int flags[$];
        n = (r.n < 0) ? $urandom_range(1, 15) : r.n;
        base = (r.sel == 1) ? 12 : 0;
        first_v = -1; done_cnt = 0; done_c = -1; last_acc = -1;
        rd_stall = 0; unstable = 0; busy_bad = 0; stall_ctr = 0; prev_s = 0;
        prev_v = 0; prev_acc = 0; finished = 0;
        load_ram(r.ram_kind);
        sel = r.sel;
        @(posedge clk); #1;
        start = 1'b1; numb = ADDR_W'(n); ready = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 300 && !finished; c++) begin
            start = 1'b0;
            numb  = ADDR_W'($urandom);
            if (m_rd) begin
                addrs.push_back(int'(m_addr));
                if (m_valid) rd_stall++;
            end
            exp_busy = (n != 0) && (done_c < 0) && !m_done;
            if (m_busy !== exp_busy) busy_bad++;
            if (m_done) begin done_cnt++; done_c = c; end
            if (m_valid && first_v < 0) first_v = c;
            if (m_valid && prev_v && !prev_acc && (int'({m_err, m_last, m_symb}) != prev_s)) unstable++;
            if (c == r.restart_at || (m_done && r.start_in_done)) begin
                start = 1'b1; numb = ADDR_W'(3);
            end
            if (r.rnd_ready) ready = 1'($urandom_range(0, 1));
            else if (m_valid && syms.size() == r.stall_idx && stall_ctr < r.stall_len) begin
                ready = 1'b0; stall_ctr++;
            end else ready = 1'b1;
            prev_acc = m_valid && ready;
            prev_v   = m_valid;
            prev_s   = int'({m_err, m_last, m_symb});
            if (prev_acc) begin
                syms.push_back(int'(m_symb));
                flags.push_back(int'({m_last, m_err}));
                last_acc = c;
            end
            if (done_c >= 0 && c >= done_c + 4) finished = 1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check({r.name, ".terminated"}, 32'(finished), 1);
        check({r.name, ".symbol_count"}, syms.size(), n);
        check({r.name, ".read_count"}, addrs.size(), n);
        for (int i = 0; i < n && i < syms.size(); i++) begin
            int a, v;
            a = (base + i) % 16;
            v = ram_val(r.sel, a);
            check($sformatf("%s.symb[%0d]", r.name, i), syms[i], v);
            check($sformatf("%s.last_err[%0d]", r.name, i), flags[i],
                  {30'd0, (i == n - 1), (v == 0 || v > 26)});
        end
        for (int i = 0; i < n && i < addrs.size(); i++)
            check($sformatf("%s.addr[%0d]", r.name, i), addrs[i], (base + i) % 16);
        check({r.name, ".first_valid_cycle"}, first_v, (n == 0) ? -1 : 2);
        check({r.name, ".done_count"}, done_cnt, 1);
        check({r.name, ".done_after_last_accept"}, done_c, last_acc + 1);
        check({r.name, ".read_while_valid"}, rd_stall, 0);
        check({r.name, ".unstable_hold"}, unstable, 0);
        check({r.name, ".busy_profile"}, busy_bad, 0);
        if (r.stall_idx >= 0) check({r.name, ".stall_cycles"}, stall_ctr, r.stall_len);
    endtask

    run_t runs[8];

    initial begin
        int acc, activity;
        runs[0] = '{"enigma",        0,  6, 0, -1, 0, 0, -1, 0};
        runs[1] = '{"backpressure",  0,  6, 0,  2, 4, 0, -1, 0};
        runs[2] = '{"empty",         0,  0, 0, -1, 0, 0, -1, 0};
        runs[3] = '{"wrap_invalid",  1,  6, 1, -1, 0, 0, -1, 0};
        runs[4] = '{"start_ignored", 0,  6, 0, -1, 0, 0,  5, 1};
        runs[5] = '{"random_full0",  0, 15, 2, -1, 0, 1, -1, 0};
        runs[6] = '{"random_full1",  1, 15, 2, -1, 0, 1, -1, 0};
        runs[7] = '{"random_count",  1, -1, 2, -1, 0, 1, -1, 0};

        rst = 1'b1; start = 1'b0; numb = '0; ready = 1'b0; sel = 0;
        load_ram(0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state_dut0",
              32'({bus0.fr_rd_o, bus0.fr_addr_o, bus0.out_valid_o, bus0.out_symb_o,
                   bus0.out_last_o, bus0.out_err_o, busy0, done0}), 0);
        check("reset_state_dut1",
              32'({bus1.fr_rd_o, bus1.fr_addr_o, bus1.out_valid_o, bus1.out_symb_o,
                   bus1.out_last_o, bus1.out_err_o, busy1, done1}), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) do_run(runs[i]);

        // Reset while the second symbol waits in SEND.
        load_ram(0);
        sel = 0;
        @(posedge clk); #1;
        start = 1'b1; numb = ADDR_W'(6); ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        acc = 0;
        for (int c = 0; c < 40; c++) begin
            if (m_valid && acc == 1) break;
            if (m_valid) begin ready = 1'b1; acc = 1; end
            else ready = 1'b0;
            @(posedge clk); #1;
        end
        check("midrun.reached_second_symbol", 32'(m_valid), 1);
        check("midrun.second_symbol", 32'(m_symb), 14);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrun.outputs_cleared",
              32'({m_rd, m_addr, m_valid, m_symb, m_last, m_err, m_busy, m_done}), 0);
        activity = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (m_done || m_valid || m_rd || m_busy) activity++;
        end
        check("midrun.quiet_after_reset", activity, 0);
        runs[0].name = "after_reset";
        do_run(runs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/enigma_result_reader.md
Name: enigma_result_reader

Overview:
Drains encoded symbols from the final RAM after an encryption run. It streams them out one at a time over a valid/ready interface, for display, UART or a host. It is the read-side counterpart of the wrapper's final-RAM writer. Start is a command pulse with a symbol count. The block issues synchronous RAM reads, registers each symbol, holds it under backpressure, flags the last symbol, and pulses done.

Parameters:
SYMB_W, 6, symbol width (0 = none, 1..26 = A..Z)
ADDR_W, 4, final-RAM address width
BASE_ADDR, 0, first RAM address read

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  reset; one clock; reset is synchronous and active-high
start_i  in  1  start command, sampled only in IDLE
symb_numb_i  in  ADDR_W  number of symbols to drain, latched at start
busy_o  out  1  high in RD, CAP, SEND
done_o  out  1  one-cycle pulse at end of run
fr_rd_o  out  1  RAM read strobe
fr_addr_o  out  ADDR_W  RAM read address
fr_data_i  in  SYMB_W  RAM read data, valid one cycle after fr_rd_o
out_symb_o  out  SYMB_W  streamed symbol
out_valid_o  out  1  out_symb_o valid
out_ready_i  in  1  sink accepts when valid&&ready at clock edge
out_last_o  out  1  qualifies the final symbol of the run
out_err_o  out  1  qualifies a symbol outside 1..26

Behaviour:
- Reset (any state, mid-run included): state=IDLE; index=0; all outputs 0. Any pending symbol is dropped; no done pulse.
- State IDLE:
  - start_i=1 and symb_numb_i!=0: latch count=symb_numb_i, index=0, go to RD.
  - start_i=1 and symb_numb_i==0: go to DONE. No reads, no valid.
- State RD (1 cycle): fr_rd_o=1, fr_addr_o=(BASE_ADDR+index) mod 2^ADDR_W; go to CAP.
- State CAP (1 cycle): fr_rd_o=0.
  - Register fr_data_i into out_symb_o.
  - out_last_o=(index==count-1).
  - out_err_o=(data==0 || data>26).
  - Go to SEND.
- State SEND: out_valid_o=1.
  - out_symb_o, out_last_o and out_err_o stay stable until the handshake.
  - On valid&&ready: out_valid_o=0. If last, go to DONE; else index+1, go to RD.
- State DONE (1 cycle): done_o=1, busy_o=0; go to IDLE.
- Latency and throughput:
  - Start sampled at edge T0. fr_rd_o is high in cycle T0..T1. out_valid_o rises after edge T2.
  - With out_ready_i held high, one symbol per 3 cycles.
- start_i outside IDLE is ignored, including in DONE. symb_numb_i changes after the start edge are ignored.
- Address wraps modulo 2^ADDR_W. The index counter is ADDR_W bits wide, so at most 15 symbols per run.
- fr_rd_o is never asserted outside RD.
- out_ready_i is ignored while out_valid_o=0.

Decomposition:
- Shared package enigma_pkg holds:
  - SYMB_W, ADDR_W
  - SYMB_NONE=0, SYMB_A=1, SYMB_Z=26
  - the reader_state_t enum {IDLE, RD, CAP, SEND, DONE}
- Single module, no sub-module; the FSM and output register are small enough to live together.

Test Plan:
- Run ENIGMA, no backpressure: preload RAM[0..5]=5,14,9,7,13,1; start with symb_numb_i=6; ready=1.
  - Stream is 5,14,9,7,13,1; last only on 1; err never set.
  - Reads at addr 0..5; first valid 3 cycles after start; done pulses once, 1 cycle after the final accept.
- Backpressure: same preload, ready low for 4 cycles on the 3rd symbol.
  - out_symb_o=9 stays stable with valid high and no new read issued.
  - Stream resumes correctly after ready returns.
- Empty run: start with symb_numb_i=0.
  - done pulses next cycle; no fr_rd_o, no out_valid_o; busy stays 0.
- Wrap and invalid symbol: BASE_ADDR=12, symb_numb_i=6, RAM[15]=40, RAM[0]=0.
  - Addresses read are 12,13,14,15,0,1.
  - err set on the 4th symbol (40) and the 5th symbol (0).
- Reset mid-run: assert rst_i during SEND of symbol 2.
  - Next cycle all outputs 0, no done.
  - A new start then reads from BASE_ADDR again.
- Start ignored when busy: pulse start_i with symb_numb_i=3 while a run of 6 is in progress.
  - Exactly 6 symbols and one done pulse are produced.
